// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// EX -> MEM pipeline stage register with valid/ready flow control, flush and
// an optional skid slot. It carries the ALU result, store data, destination
// register index and a control bundle from execute to memory.
//
// Build option:
//   EX_MEM_SKID_EN  defined     : two slots (main + skid). in_ready comes
//                                 straight from a flop. occupancy is 0..2.
//                   not defined : single slot. in_ready = !out_valid ||
//                                 out_ready (combinational). occupancy is 0..1.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   flush             synchronous squash of every held entry
//   in_valid/in_ready EX-side handshake
//   aluout_in, writedata_in, writereg_in, ctrl_in   EX-side payload
//   out_valid/out_ready MEM-side handshake
//   aluout_out, writedata_out, writereg_out, ctrl_out head-entry payload
//   occupancy         number of entries held
//   stall_cnt         saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   aluout_in,
  input  logic [XLEN-1:0]   writedata_in,
  input  logic [REG_W-1:0]  writereg_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   aluout_out,
  output logic [XLEN-1:0]   writedata_out,
  output logic [REG_W-1:0]  writereg_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = 2 * XLEN + REG_W + CTRL_W;

  logic              main_valid_q, main_valid_d;
  logic [PW-1:0]     main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PW-1:0]     in_data;
  logic              in_fire;
  logic              out_fire;

  assign in_data   = {aluout_in, writedata_in, writereg_in, ctrl_in};
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid_q && out_ready;
  assign out_valid = main_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign {aluout_out, writedata_out, writereg_out, ctrl_out} = main_data_q;

`ifdef EX_MEM_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_data_q, skid_data_d;

  // Skid state alone gates acceptance, so out_ready never reaches in_ready.
  assign in_ready  = !skid_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state for main and skid slots; flush beats every load.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || (out_fire && !skid_valid_q)) begin
      // Main is free (or freeing up) and nothing waits in skid.
      if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (out_fire) begin
      // Main drains with skid full: skid advances, keeping FIFO order.
      main_data_d = skid_data_q;
      if (in_fire) begin
        skid_data_d = in_data;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else begin
      // Main held: a new entry parks in skid.
      if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Skid slot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= {PW{1'b0}};
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready  = !main_valid_q || out_ready;
  assign occupancy = {1'b0, main_valid_q};

  // Next-state for the single slot; flush beats the load.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (in_fire) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
  end
`endif

  // Stall counter: counts held-but-not-consumed cycles, sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Main slot and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= {PW{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule
